// File: rtl/apb_write_sequencer.sv
// rtl/apb_write_sequencer.sv - two-requester APB write sequencer issuing 3-beat commands
module apb_write_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic       pclk,
  input  logic       preset_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_p0,
  input  logic [7:0] req0_p1,
  input  logic [4:0] req0_size,
  input  logic       req1_valid,
  input  logic [7:0] req1_p0,
  input  logic [7:0] req1_p1,
  input  logic [4:0] req1_size,
  output logic       ack0,
  output logic       ack1,
  output logic       err,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [1:0] paddr,
  output logic [7:0] pwdata,
  input  logic       pready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [1:0] beat, beat_nx;
  logic [7:0] wait_cnt, wait_nx;
  logic       last_grant, last_nx;
  logic       granted, granted_nx;
  logic       err_q, err_nx;
  logic [7:0] p0_q, p0_nx, p1_q, p1_nx;
  logic [4:0] size_q, size_nx;
  logic       pick;

  // With both requesters pending, the one not served last wins.
  assign pick = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state      <= IDLE;
      beat       <= 2'd0;
      wait_cnt   <= 8'd0;
      last_grant <= 1'b1;
      granted    <= 1'b0;
      err_q      <= 1'b0;
      p0_q       <= 8'd0;
      p1_q       <= 8'd0;
      size_q     <= 5'd0;
    end else begin
      state      <= state_nx;
      beat       <= beat_nx;
      wait_cnt   <= wait_nx;
      last_grant <= last_nx;
      granted    <= granted_nx;
      err_q      <= err_nx;
      p0_q       <= p0_nx;
      p1_q       <= p1_nx;
      size_q     <= size_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    beat_nx    = beat;
    wait_nx    = wait_cnt;
    last_nx    = last_grant;
    granted_nx = granted;
    err_nx     = err_q;
    p0_nx      = p0_q;
    p1_nx      = p1_q;
    size_nx    = size_q;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          granted_nx = pick;
          last_nx    = pick;
          p0_nx      = pick ? req1_p0 : req0_p0;
          p1_nx      = pick ? req1_p1 : req0_p1;
          size_nx    = pick ? req1_size : req0_size;
          beat_nx    = 2'd0;
          wait_nx    = 8'd0;
          err_nx     = 1'b0;
          state_nx   = SETUP;
        end
      end
      SETUP: begin
        wait_nx  = 8'd0;
        state_nx = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          if (beat == 2'd2) begin
            err_nx   = 1'b0;
            state_nx = RESP;
          end else begin
            beat_nx  = beat + 2'd1;
            state_nx = SETUP;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          // Slave stalled too long: abandon the remaining beats.
          err_nx   = 1'b1;
          state_nx = RESP;
        end else begin
          wait_nx = wait_cnt + 8'd1;
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign psel    = (state == SETUP) || (state == ACCESS);
  assign penable = (state == ACCESS);
  assign pwrite  = psel;
  assign paddr   = psel ? beat : 2'd0;
  assign ack0    = (state == RESP) && !granted;
  assign ack1    = (state == RESP) && granted;
  assign err     = (state == RESP) && err_q;

  always_comb begin
    pwdata = 8'd0;
    if (psel) begin
      case (beat)
        2'd0:    pwdata = p0_q;
        2'd1:    pwdata = p1_q;
        2'd2:    pwdata = {3'b000, size_q};
        default: pwdata = 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_write_sequencer.sv
// tb/tb_apb_write_sequencer.sv - scoreboard bench for apb_write_sequencer
module tb_apb_write_sequencer;
  localparam int TO = 15;

  logic       pclk = 1'b0;
  logic       preset_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_p0 = 8'd0, req0_p1 = 8'd0, req1_p0 = 8'd0, req1_p1 = 8'd0;
  logic [4:0] req0_size = 5'd0, req1_size = 5'd0;
  logic       ack0, ack1, err, psel, penable, pwrite;
  logic [1:0] paddr;
  logic [7:0] pwdata;
  logic       pready = 1'b0;

  apb_write_sequencer #(.TIMEOUT(TO)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req0_valid(req0_valid), .req0_p0(req0_p0), .req0_p1(req0_p1), .req0_size(req0_size),
    .req1_valid(req1_valid), .req1_p0(req1_p0), .req1_p1(req1_p1), .req1_size(req1_size),
    .ack0(ack0), .ack1(ack1), .err(err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic            id;
    logic [2:0][7:0] d;
    logic [2:0][7:0] w;
  } cmd_t;

  cmd_t exp_q[$];
  cmd_t plan_q[$];
  int   checks = 0;
  int   failures = 0;
  logic lg = 1'b1;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic cmd_t rand_cmd(input logic id);
    cmd_t c;
    c.id = id;
    c.d[0] = 8'($urandom);
    c.d[1] = 8'($urandom);
    c.d[2] = {3'b000, 5'($urandom)};
    for (int i = 0; i < 3; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6)       c.w[i] = 8'd0;
      else if (r < 8)  c.w[i] = 8'($urandom_range(1, 4));
      else if (r == 8) c.w[i] = 8'(TO - 1);
      else             c.w[i] = 8'(TO);
    end
    return c;
  endfunction

  // Slave: holds pready low for the planned number of ACCESS cycles of each beat.
  int acc_cnt = 0;
  always @(posedge pclk) begin
    #1;
    if (psel && penable && plan_q.size() > 0) begin
      pready = (acc_cnt >= int'(plan_q[0].w[paddr]));
      acc_cnt++;
    end else begin
      pready = 1'b0;
      acc_cnt = 0;
    end
  end

  // Monitor: protocol rules every cycle, scoreboard compare on each ack.
  logic [1:0] obs_addr [3];
  logic [7:0] obs_data [3];
  int         obs_n = 0, psel_cyc = 0;
  logic       prev_psel = 1'b0, prev_ack = 1'b0;
  logic [1:0] prev_addr = 2'd0;
  logic [7:0] prev_data = 8'd0;

  always @(negedge pclk) begin
    if (!preset_n) begin
      obs_n = 0;
      psel_cyc = 0;
    end else begin
      if (pwrite != psel) check("pwrite_eq_psel", pwrite, psel);
      if (!psel && (paddr != 2'd0 || pwdata != 8'd0)) check("idle_bus_zero", {paddr, pwdata}, 0);
      if (ack0 && ack1) check("ack_exclusive", 1, 0);
      if (err && !(ack0 || ack1)) check("err_without_ack", 1, 0);
      if (penable) begin
        check("penable_needs_psel", psel, 1);
        check("access_after_setup", prev_psel, 1);
        check("access_addr_stable", paddr, prev_addr);
        check("access_data_stable", pwdata, prev_data);
      end
      if (psel) psel_cyc++;
      if (psel && penable && pready) begin
        if (obs_n < 3) begin
          obs_addr[obs_n] = paddr;
          obs_data[obs_n] = pwdata;
        end
        obs_n++;
      end
      if (ack0 || ack1) begin
        check("ack_one_cycle", prev_ack, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 0, 1);
        end else begin
          cmd_t e;
          int   ab, cyc;
          e = exp_q.pop_front();
          void'(plan_q.pop_front());
          ab = 3;
          for (int i = 0; i < 3; i++) if (ab == 3 && int'(e.w[i]) >= TO) ab = i;
          cyc = 0;
          for (int i = 0; i < ab; i++) cyc += int'(e.w[i]) + 2;
          if (ab < 3) cyc += 1 + TO;
          check("ack_requester", ack1, e.id);
          check("err_flag", err, (ab < 3) ? 1 : 0);
          check("beats_done", obs_n, ab);
          for (int i = 0; i < ab && i < obs_n; i++) begin
            check("beat_addr", obs_addr[i], i);
            check("beat_data", obs_data[i], e.d[i]);
          end
          check("psel_cycles", psel_cyc, cyc);
        end
        obs_n = 0;
        psel_cyc = 0;
      end
    end
    prev_psel = psel && !penable || penable;
    prev_addr = paddr;
    prev_data = pwdata;
    prev_ack  = ack0 || ack1;
  end

  task automatic load(input cmd_t c);
    if (c.id) begin
      req1_p0 = c.d[0]; req1_p1 = c.d[1]; req1_size = c.d[2][4:0]; req1_valid = 1'b1;
    end else begin
      req0_p0 = c.d[0]; req0_p1 = c.d[1]; req0_size = c.d[2][4:0]; req0_valid = 1'b1;
    end
  endtask

  // Issue one round; the arbitration outcome is predicted from the round-robin rule.
  task automatic run_round(input logic u0, input logic u1, input cmd_t c0, input cmd_t c1);
    int budget;
    c0.id = 1'b0;
    c1.id = 1'b1;
    if (u0 && u1) begin
      if (lg) begin
        exp_q.push_back(c0); plan_q.push_back(c0);
        exp_q.push_back(c1); plan_q.push_back(c1);
        lg = 1'b1;
      end else begin
        exp_q.push_back(c1); plan_q.push_back(c1);
        exp_q.push_back(c0); plan_q.push_back(c0);
        lg = 1'b0;
      end
    end else if (u0) begin
      exp_q.push_back(c0); plan_q.push_back(c0); lg = 1'b0;
    end else begin
      exp_q.push_back(c1); plan_q.push_back(c1); lg = 1'b1;
    end
    @(negedge pclk);
    if (u0) load(c0);
    if (u1) load(c1);
    budget = 0;
    while ((req0_valid || req1_valid) && budget < 2000) begin
      @(negedge pclk);
      if (ack0) req0_valid = 1'b0;
      if (ack1) req1_valid = 1'b0;
      budget++;
    end
    if (budget >= 2000) begin
      check("round_timeout", 0, 1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
  endtask

  initial begin
    cmd_t a, b;
    int   budget;

    repeat (3) begin
      @(negedge pclk);
      check("reset_outputs", {psel, penable, pwrite, paddr, pwdata, ack0, ack1, err}, 0);
    end
    preset_n = 1'b1;

    a = rand_cmd(0); a.w = '0;
    b = rand_cmd(1); b.w = '0;
    run_round(1, 1, a, b);
    a = rand_cmd(0); a.w = '0;
    b = rand_cmd(1); b.w = '0;
    run_round(1, 1, a, b);

    a.d[0] = 8'hA5; a.d[1] = 8'h3C; a.d[2] = 8'd17; a.w = '0;
    run_round(1, 0, a, b);

    a = rand_cmd(0); a.w = '0; a.w[1] = 8'd3;
    run_round(1, 0, a, b);

    a = rand_cmd(0); a.w = '0; a.w[0] = 8'(TO);
    run_round(1, 0, a, b);

    for (int n = 0; n < 40; n++) begin
      int sel;
      sel = int'($urandom_range(1, 3));
      a = rand_cmd(0);
      b = rand_cmd(1);
      run_round(sel[0], sel[1], a, b);
    end

    a = rand_cmd(0); a.w = '0; a.w[2] = 8'(TO + 5);
    exp_q.push_back(a); plan_q.push_back(a);
    @(negedge pclk);
    load(a);
    budget = 0;
    while (!(psel && penable && paddr == 2'd2) && budget < 200) begin
      @(negedge pclk);
      budget++;
    end
    check("reach_beat2_access", (budget < 200) ? 1 : 0, 1);
    preset_n = 1'b0;
    #1;
    check("reset_mid_outputs", {psel, penable, pwrite, paddr, pwdata, ack0, ack1, err}, 0);
    exp_q.delete();
    plan_q.delete();
    req0_valid = 1'b0;
    lg = 1'b1;
    repeat (2) begin
      @(negedge pclk);
      check("reset_no_ack", {ack0, ack1}, 0);
    end
    preset_n = 1'b1;
    b = rand_cmd(1); b.w = '0;
    run_round(0, 1, a, b);

    repeat (3) @(negedge pclk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
